sw_poll_ctrl: RTL and testbench



---
 rtl/sw_poll_ctrl.sv | 168 ++++++++++++++++
 tb/tb_sw_poll_ctrl.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/sw_poll_ctrl.sv
// sw_poll_ctrl: polls a switch PIO over Avalon-MM, debounces bit 0 and reports level changes.
// Optional macro SW_POLL_IRQ_EN adds a registered irq output (evt_valid | err_timeout).
module sw_poll_ctrl #(
  parameter int POLL_DIV     = 50000,
  parameter int DEBOUNCE_CNT = 4,
  parameter int TIMEOUT      = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        sw_level,
  output logic        evt_valid,
  output logic        evt_level,
  input  logic        evt_ready,
  output logic        err_timeout,
  output logic        err_overrun
`ifdef SW_POLL_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int DIV_W = $clog2(POLL_DIV);
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(POLL_DIV - 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
  localparam logic [3:0]       DEB_C    = 4'(DEBOUNCE_CNT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_EVAL
  } state_t;

  state_t           state_reg;
  logic [DIV_W-1:0] div_reg;
  logic [TMO_W-1:0] tmo_reg;
  logic             sample_reg;
  logic             cand_reg;
  logic [3:0]       cnt_reg;
  logic             avm_read_reg;
  logic             sw_level_reg;
  logic             evt_valid_reg;
  logic             evt_level_reg;
  logic             err_timeout_reg;
  logic             err_overrun_reg;

  logic             cand_next;
  logic [3:0]       cnt_next;
  logic             qualify;
  logic             consume;
  logic             unused_rd;

  // Only bit 0 of the PIO word carries the switch.
  assign unused_rd = ^avm_readdata[31:1];

  always_comb begin
    cand_next = cand_reg;
    cnt_next  = cnt_reg;
    if (sample_reg == cand_reg) begin
      if (cnt_reg != DEB_C)
        cnt_next = cnt_reg + 4'd1;
    end else begin
      cand_next = sample_reg;
      cnt_next  = 4'd1;
    end
  end

  assign qualify = (state_reg == S_EVAL) && (cnt_next == DEB_C) && (cand_next != sw_level_reg);
  assign consume = evt_valid_reg & evt_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      div_reg         <= DIV_LOAD;
      tmo_reg         <= '0;
      sample_reg      <= 1'b0;
      cand_reg        <= 1'b0;
      cnt_reg         <= 4'd0;
      avm_read_reg    <= 1'b0;
      sw_level_reg    <= 1'b0;
      evt_valid_reg   <= 1'b0;
      evt_level_reg   <= 1'b0;
      err_timeout_reg <= 1'b0;
      err_overrun_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (div_reg == '0) begin
            state_reg    <= S_REQ;
            avm_read_reg <= 1'b1;
          end else begin
            div_reg <= div_reg - 1'b1;
          end
        end
        S_REQ: begin
          if (!avm_waitrequest) begin
            avm_read_reg <= 1'b0;
            tmo_reg      <= '0;
            state_reg    <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (avm_readdatavalid) begin
            sample_reg <= avm_readdata[0];
            state_reg  <= S_EVAL;
          end else if (tmo_reg == TMO_LAST) begin
            // Abandon the poll; the slave never answered.
            err_timeout_reg <= 1'b1;
            div_reg         <= DIV_LOAD;
            state_reg       <= S_IDLE;
          end else begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
        S_EVAL: begin
          cand_reg <= cand_next;
          cnt_reg  <= cnt_next;
          if (qualify)
            sw_level_reg <= cand_next;
          div_reg   <= DIV_LOAD;
          state_reg <= S_IDLE;
        end
        default: begin
          div_reg   <= DIV_LOAD;
          state_reg <= S_IDLE;
        end
      endcase

      // A new qualification always wins over a same-cycle consume.
      if (qualify) begin
        evt_valid_reg <= 1'b1;
        evt_level_reg <= cand_next;
        if (evt_valid_reg && !evt_ready)
          err_overrun_reg <= 1'b1;
      end else if (consume) begin
        evt_valid_reg <= 1'b0;
      end
    end
  end

  assign avm_address = 2'b00;
  assign avm_read    = avm_read_reg;
  assign sw_level    = sw_level_reg;
  assign evt_valid   = evt_valid_reg;
  assign evt_level   = evt_level_reg;
  assign err_timeout = err_timeout_reg;
  assign err_overrun = err_overrun_reg;

`ifdef SW_POLL_IRQ_EN
  logic irq_reg;

  always_ff @(posedge clk) begin
    if (reset)
      irq_reg <= 1'b0;
    else
      irq_reg <= evt_valid_reg | err_timeout_reg;
  end

  assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_sw_poll_ctrl.sv
// Directed bench for sw_poll_ctrl: table of polls plus stall, timeout, reset and ack corner sequences.
module tb_sw_poll_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = 32'h0;
  logic        avm_readdatavalid = 1'b0;
  logic        sw_level;
  logic        evt_valid;
  logic        evt_level;
  logic        evt_ready = 1'b0;
  logic        err_timeout;
  logic        err_overrun;
`ifdef SW_POLL_IRQ_EN
  logic        irq;
`endif

  sw_poll_ctrl #(.POLL_DIV(8), .DEBOUNCE_CNT(3), .TIMEOUT(16)) dut (
    .clk               (clk),
    .reset             (reset),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .sw_level          (sw_level),
    .evt_valid         (evt_valid),
    .evt_level         (evt_level),
    .evt_ready         (evt_ready),
    .err_timeout       (err_timeout),
    .err_overrun       (err_overrun)
`ifdef SW_POLL_IRQ_EN
    ,
    .irq               (irq)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int last_rise = 0;
  int period = 0;
  int last_hi = 0;
  int last_acc = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_read && !avm_waitrequest)
      acc_cnt <= acc_cnt + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    bit smp;
    bit ack;
    bit sw;
    bit vld;
    bit lvl;
    bit ovr;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0d exp=%0d", name, act, exp);
    end
  endtask

  task automatic ack_pulse();
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  // One poll: wait for the request, stall it, accept it, optionally answer one cycle later.
  task automatic poll(input bit val, input int stall, input bit give_rdv, input bit ack_eval);
    int guard;
    int hi;
    int acc0;
    guard = 0;
    while (avm_read !== 1'b1 && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk("read_req", avm_read, 1);
    if (avm_read !== 1'b1) return;
    period = cyc - last_rise;
    last_rise = cyc;
    acc0 = acc_cnt;
    hi = 1;
    for (int i = 0; i < stall; i++) begin
      avm_waitrequest = 1'b1;
      @(negedge clk);
      if (avm_read) hi++;
    end
    avm_waitrequest = 1'b0;
    @(negedge clk);
    last_hi = hi;
    last_acc = acc_cnt - acc0;
    if (!give_rdv) return;
    avm_readdatavalid = 1'b1;
    avm_readdata = {31'h2AAAAAAA, val};
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'h0;
    evt_ready = ack_eval;
    @(negedge clk);
    evt_ready = 1'b0;
  endtask

  initial begin
    vt[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[2]  = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[11] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    vt[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[13] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk("rst_read", avm_read, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_sw", sw_level, 0);
    chk("rst_valid", evt_valid, 0);
    chk("rst_level", evt_level, 0);
    chk("rst_tmo", err_timeout, 0);
    chk("rst_ovr", err_overrun, 0);
`ifdef SW_POLL_IRQ_EN
    chk("rst_irq", irq, 0);
`endif

    for (int i = 0; i < 14; i++) begin
      if (vt[i].ack) ack_pulse();
      poll(vt[i].smp, 0, 1'b1, 1'b0);
      $display("vec %0d smp=%0d ack=%0d -> sw=%0d vld=%0d lvl=%0d ovr=%0d",
               i, vt[i].smp, vt[i].ack, sw_level, evt_valid, evt_level, err_overrun);
      chk("vec_sw", sw_level, vt[i].sw);
      chk("vec_valid", evt_valid, vt[i].vld);
      chk("vec_level", evt_level, vt[i].lvl);
      chk("vec_ovr", err_overrun, vt[i].ovr);
      chk("vec_acc", last_acc, 1);
      if (i > 0) chk("vec_period", period, 11);
    end

    poll(1'b0, 0, 1'b0, 1'b0);
    repeat (15) @(negedge clk);
    chk("tmo_early", err_timeout, 0);
    @(negedge clk);
    chk("tmo_set", err_timeout, 1);
    chk("tmo_read", avm_read, 0);
    chk("tmo_sw", sw_level, 1);
    $display("timeout poll -> err_timeout=%0d sw=%0d", err_timeout, sw_level);
    poll(1'b1, 0, 1'b1, 1'b0);
    chk("tmo_next_acc", last_acc, 1);
    chk("tmo_next_sw", sw_level, 1);
    chk("tmo_sticky", err_timeout, 1);

    poll(1'b1, 5, 1'b1, 1'b0);
    $display("stall poll -> read_high=%0d accepts=%0d", last_hi, last_acc);
    chk("stall_hi", last_hi, 6);
    chk("stall_acc", last_acc, 1);

    poll(1'b1, 0, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    avm_readdatavalid = 1'b1;
    avm_readdata = 32'h1;
    @(negedge clk);
    avm_readdatavalid = 1'b0;
    avm_readdata = 32'h0;
    @(negedge clk);
    $display("reset in WAIT -> sw=%0d vld=%0d tmo=%0d ovr=%0d", sw_level, evt_valid, err_timeout, err_overrun);
    chk("rw_read", avm_read, 0);
    chk("rw_sw", sw_level, 0);
    chk("rw_valid", evt_valid, 0);
    chk("rw_level", evt_level, 0);
    chk("rw_tmo", err_timeout, 0);
    chk("rw_ovr", err_overrun, 0);
`ifdef SW_POLL_IRQ_EN
    chk("rw_irq", irq, 0);
`endif

    poll(1'b1, 0, 1'b1, 1'b0);
    poll(1'b1, 0, 1'b1, 1'b0);
    chk("co_pre_sw", sw_level, 0);
    poll(1'b1, 0, 1'b1, 1'b0);
    chk("co_q1_valid", evt_valid, 1);
    chk("co_q1_level", evt_level, 1);
`ifdef SW_POLL_IRQ_EN
    @(negedge clk);
    chk("co_irq", irq, 1);
`endif
    poll(1'b0, 0, 1'b1, 1'b0);
    poll(1'b0, 0, 1'b1, 1'b0);
    poll(1'b0, 0, 1'b1, 1'b1);
    $display("coincident ack -> sw=%0d vld=%0d lvl=%0d ovr=%0d", sw_level, evt_valid, evt_level, err_overrun);
    chk("co_sw", sw_level, 0);
    chk("co_valid", evt_valid, 1);
    chk("co_level", evt_level, 0);
    chk("co_ovr", err_overrun, 0);
    ack_pulse();
    chk("co_consumed", evt_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
